lgn_frame_ctrl: RTL

Frame sequencer in front of the `lgn` inference datapath. It accepts a 784-pixel binarised image as a valid/ready byte stream and drives the `lgn` shift-register loading through `write_enable` and `ui_in`. After the last byte it waits a fixed number of cycles for the combinational network, popcount and argmax to settle. It then captures the winning category index and score into registers and holds them under a valid/ready result handshake.

---
 rtl/lgn_frame_ctrl_if.sv | 28 ++
 rtl/lgn_frame_ctrl.sv | 130 +++++++++++++
 2 files changed

// File: rtl/lgn_frame_ctrl_if.sv
// lgn_frame_ctrl_if: byte-stream input, lgn loading, lgn result and result
// handshake signals of the frame sequencer, grouped into one bundle.
// master = upstream/downstream environment, slave = the controller.
interface lgn_frame_ctrl_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       lgn_we;
  logic [7:0] lgn_data;
  logic [3:0] lgn_index;
  logic [7:0] lgn_value;
  logic       res_valid;
  logic       res_ready;
  logic [3:0] res_index;
  logic [7:0] res_value;
  logic       busy;
  logic       err;

  modport master (
    output in_valid, in_data, lgn_index, lgn_value, res_ready,
    input  in_ready, lgn_we, lgn_data, res_valid, res_index, res_value, busy, err
  );

  modport slave (
    input  in_valid, in_data, lgn_index, lgn_value, res_ready,
    output in_ready, lgn_we, lgn_data, res_valid, res_index, res_value, busy, err
  );
endinterface

// File: rtl/lgn_frame_ctrl.sv
// lgn_frame_ctrl: loads one binarised image into the lgn shift register byte by
// byte, waits for the network/argmax to settle, then captures and holds the
// winning index/score under a valid/ready handshake.
// Optional build macro LGN_CTRL_TIMEOUT_EN: aborts a frame that stalls in LOAD
// for TIMEOUT_CYCLES cycles and pulses err for one cycle.
module lgn_frame_ctrl #(
  parameter int BYTES_PER_FRAME = 98,
  parameter int SETTLE_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES  = 255
) (
  input logic            clk,
  input logic            rst,
  lgn_frame_ctrl_if.slave bus
);

  localparam int              CNT_W       = $clog2(BYTES_PER_FRAME + 1);
  localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(BYTES_PER_FRAME - 1);
  localparam logic [7:0]      SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SETTLE, RESULT} state_t;

  state_t           state_reg;
  logic [CNT_W-1:0] byte_cnt_reg;
  logic [7:0]       settle_cnt_reg;
  logic             res_valid_reg;
  logic [3:0]       res_index_reg;
  logic [7:0]       res_value_reg;
  logic             in_ready;
  logic             xfer;
  logic             stall_limit;

  assign in_ready      = (state_reg == IDLE) || (state_reg == LOAD);
  assign xfer          = bus.in_valid & in_ready;
  assign bus.in_ready  = in_ready;
  // lgn shifts on write_enable, so every accepted byte goes straight through
  assign bus.lgn_we    = xfer;
  assign bus.lgn_data  = bus.in_data;
  assign bus.res_valid = res_valid_reg;
  assign bus.res_index = res_index_reg;
  assign bus.res_value = res_value_reg;
  assign bus.busy      = (state_reg != IDLE);

`ifdef LGN_CTRL_TIMEOUT_EN
  localparam int               STALL_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(TIMEOUT_CYCLES - 1);

  logic [STALL_W-1:0] stall_cnt_reg;
  logic               err_reg;

  // the limit cycle is the TIMEOUT_CYCLES-th LOAD cycle without a transfer;
  // a transfer in that cycle wins and keeps the frame alive
  assign stall_limit = (state_reg == LOAD) && !xfer && (stall_cnt_reg == STALL_LAST);
  assign bus.err     = err_reg;

  // stall counter and one-cycle abort pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_reg <= '0;
      err_reg       <= 1'b0;
    end else begin
      err_reg <= stall_limit;
      if ((state_reg == LOAD) && !xfer && !stall_limit)
        stall_cnt_reg <= stall_cnt_reg + STALL_W'(1);
      else
        stall_cnt_reg <= '0;
    end
  end
`else
  assign stall_limit = 1'b0;
  // constant 0; the parameter reference keeps TIMEOUT_CYCLES from dangling here
  assign bus.err     = 1'b0 & (TIMEOUT_CYCLES != 0);
`endif

  // frame sequencer: load bytes, settle, capture, hold result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      byte_cnt_reg   <= '0;
      settle_cnt_reg <= '0;
      res_valid_reg  <= 1'b0;
      res_index_reg  <= '0;
      res_value_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          byte_cnt_reg <= '0;
          if (xfer) begin
            byte_cnt_reg <= CNT_W'(1);
            if (BYTES_PER_FRAME == 1) begin
              state_reg      <= SETTLE;
              settle_cnt_reg <= SETTLE_LOAD;
            end else begin
              state_reg <= LOAD;
            end
          end
        end
        LOAD: begin
          if (xfer) begin
            byte_cnt_reg <= byte_cnt_reg + CNT_W'(1);
            if (byte_cnt_reg == LAST_CNT) begin
              state_reg      <= SETTLE;
              settle_cnt_reg <= SETTLE_LOAD;
            end
          end else if (stall_limit) begin
            state_reg    <= IDLE;
            byte_cnt_reg <= '0;
          end
        end
        SETTLE: begin
          if (settle_cnt_reg == 8'd0) begin
            state_reg     <= RESULT;
            res_valid_reg <= 1'b1;
            res_index_reg <= bus.lgn_index;
            res_value_reg <= bus.lgn_value;
          end else begin
            settle_cnt_reg <= settle_cnt_reg - 8'd1;
          end
        end
        RESULT: begin
          if (bus.res_ready) begin
            state_reg     <= IDLE;
            res_valid_reg <= 1'b0;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
